// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared segment codes, FSM state type and decimal bound helper
// Contents: SEG_* active-low segment codes (bit 6 = g .. bit 0 = a), fsm_state_e,
//   pow10() constant function, seg_code() nibble decoder.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} fsm_state_e;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  // Letters only appear when the digit was loaded as a raw hex nibble.
  function automatic logic [6:0] seg_code(input logic [3:0] nib, input logic hex);
    logic [6:0] s;
    case (nib)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = hex ? SEG_A : SEG_BLANK;
      4'hB: s = hex ? SEG_B : SEG_BLANK;
      4'hC: s = hex ? SEG_C : SEG_BLANK;
      4'hD: s = hex ? SEG_D : SEG_BLANK;
      4'hE: s = hex ? SEG_E : SEG_BLANK;
      default: s = hex ? SEG_F : SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_multi_driver_if.sv
// rtl/seg7_multi_driver_if.sv - value handshake bundle between producer and display driver
// Signals: num (BIN_W), num_valid, num_ready; hex_mode when HEX_MODE_EN is defined.
interface seg7_multi_driver_if #(
  parameter int BIN_W = 27
) ();
  logic [BIN_W-1:0] num;
  logic             num_valid;
  logic             num_ready;
`ifdef HEX_MODE_EN
  logic             hex_mode;

  modport master (output num, output num_valid, output hex_mode, input num_ready);
  modport slave  (input num, input num_valid, input hex_mode, output num_ready);
`else
  modport master (output num, output num_valid, input num_ready);
  modport slave  (input num, input num_valid, output num_ready);
`endif
endinterface

// File: rtl/seg7_multi_driver_bin2bcd_seq.sv
// rtl/seg7_multi_driver_bin2bcd_seq.sv - sequential double-dabble binary to BCD engine
// Ports: clk, rst_n (async active-low), start_i loads bin_i, done_o is high during the
//   cycle whose closing edge performs the last shift, bcd_o holds the result afterwards.
module bin2bcd_seq #(
  parameter int BIN_W      = 27,
  parameter int NUM_DIGITS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [BIN_W-1:0]        bin_i,
  output logic                    done_o,
  output logic [4*NUM_DIGITS-1:0] bcd_o
);
  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  logic             run_q;
  logic [CNT_W-1:0] cnt_q;
  logic [BIN_W-1:0] sh_q;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] adj;

  // Add 3 to every nibble above 4 before the shift so it carries correctly into decimal.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] > 4'd4) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Signalled one cycle early so the caller can move to its commit on the final edge.
  assign done_o = run_q && (cnt_q == CNT_W'(BIN_W - 1));
  assign bcd_o  = bcd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      sh_q  <= '0;
      bcd_q <= '0;
    end else if (start_i) begin
      run_q <= 1'b1;
      cnt_q <= '0;
      sh_q  <= bin_i;
      bcd_q <= '0;
    end else if (run_q) begin
      bcd_q <= {adj[BCD_W-2:0], sh_q[BIN_W-1]};
      sh_q  <= sh_q << 1;
      cnt_q <= cnt_q + 1'b1;
      if (done_o) run_q <= 1'b0;
    end
  end
endmodule

// File: rtl/seg7_multi_driver.sv
// rtl/seg7_multi_driver.sv - multiplexed NUM_DIGITS 7-segment driver with sequential BCD conversion
// Optional feature macro HEX_MODE_EN: bus.hex_mode=1 at acceptance loads raw hex nibbles.
// Ports: clock_100, reset (async active-low); bus (num/num_valid/num_ready);
//   blank_lz, dp_mask in; controls, dp, seg_ctrl (active-low pins), busy, overflow out.
module seg7_multi_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int BIN_W      = 27,
  parameter int DIV_COUNT  = 12500
) (
  input  logic                  clock_100,
  input  logic                  reset,
  seg7_multi_driver_if.slave    bus,
  input  logic                  blank_lz,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  output logic [6:0]            controls,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] seg_ctrl,
  output logic                  busy,
  output logic                  overflow
);
  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = $clog2(DIV_COUNT);
  localparam logic [63:0] MAX_VAL = pow10(NUM_DIGITS) - 64'd1;

  fsm_state_e            state_q, state_d;
  logic                  accept, hex_sel, conv_start, conv_done, commit_hex;
  logic [BCD_W-1:0]      conv_bcd, commit_data;
  logic                  ovf_cap_q;
  logic [BCD_W-1:0]      buf_q;
  logic                  buf_ovf_q, buf_hex_q;
  logic [PRE_W-1:0]      pre_q, pre_d;
  logic                  tick;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [6:0]            controls_q, controls_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] seg_ctrl_q, seg_ctrl_d;
  logic [NUM_DIGITS-1:0] upper_zero;
  logic                  zero_run;
  logic [3:0]            nib [NUM_DIGITS];

  assign accept     = bus.num_valid & bus.num_ready;
  assign conv_start = accept & ~hex_sel;

  // ---------------- conversion FSM ----------------
  always_ff @(posedge clock_100 or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = hex_sel ? COMMIT : CONV;
      CONV:    if (conv_done) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.num_ready = (state_q == IDLE);
    busy          = (state_q != IDLE);
  end

  bin2bcd_seq #(
    .BIN_W      (BIN_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk     (clock_100),
    .rst_n   (reset),
    .start_i (conv_start),
    .bin_i   (bus.num),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

`ifdef HEX_MODE_EN
  logic [BCD_W-1:0] hold_q;
  logic             hex_cap_q;

  assign hex_sel = bus.hex_mode;

  always_ff @(posedge clock_100 or negedge reset) begin
    if (!reset) begin
      hold_q    <= '0;
      hex_cap_q <= 1'b0;
    end else if (accept) begin
      hold_q    <= BCD_W'(bus.num);
      hex_cap_q <= bus.hex_mode;
    end
  end

  assign commit_hex  = hex_cap_q;
  assign commit_data = hex_cap_q ? hold_q : conv_bcd;
`else
  assign hex_sel     = 1'b0;
  assign commit_hex  = 1'b0;
  assign commit_data = conv_bcd;
`endif

  // Overflow is judged on the accepted binary value; the BCD of an out-of-range value
  // is truncated but never shown, since dashes replace every digit.
  always_ff @(posedge clock_100 or negedge reset) begin
    if (!reset) begin
      ovf_cap_q <= 1'b0;
      buf_q     <= '0;
      buf_ovf_q <= 1'b0;
      buf_hex_q <= 1'b0;
    end else begin
      if (accept) ovf_cap_q <= ~hex_sel & (64'(bus.num) > MAX_VAL);
      if (state_q == COMMIT) begin
        buf_q     <= commit_data;
        buf_ovf_q <= ovf_cap_q;
        buf_hex_q <= commit_hex;
      end
    end
  end

  assign overflow = buf_ovf_q;

  // ---------------- scan ----------------
  always_comb begin
    pre_d = pre_q + 1'b1;
    tick  = 1'b0;
    if (pre_q == PRE_W'(DIV_COUNT - 1)) begin
      pre_d = '0;
      tick  = 1'b1;
    end
  end

  always_comb begin
    idx_d = idx_q;
    if (tick) idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_nib
    assign nib[g] = buf_q[4*g +: 4];
  end

  // upper_zero[i]: every digit from i up to the most significant one is zero.
  always_comb begin
    upper_zero = '0;
    zero_run   = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run      = zero_run & (nib[i] == 4'd0);
      upper_zero[i] = zero_run;
    end
  end

  // Decoded for the digit about to be selected so anode and segments switch together.
  always_comb begin
    controls_d = seg_code(nib[idx_d], buf_hex_q);
    if (buf_ovf_q) controls_d = SEG_DASH;
    else if (blank_lz && (idx_d != '0) && upper_zero[idx_d]) controls_d = SEG_BLANK;
    dp_d       = ~dp_mask[idx_d];
    seg_ctrl_d = ~(NUM_DIGITS'(1) << idx_d);
  end

  always_ff @(posedge clock_100 or negedge reset) begin
    if (!reset) begin
      pre_q      <= '0;
      idx_q      <= '0;
      controls_q <= SEG_BLANK;
      dp_q       <= 1'b1;
      seg_ctrl_q <= '1;
    end else begin
      pre_q <= pre_d;
      if (tick) begin
        idx_q      <= idx_d;
        controls_q <= controls_d;
        dp_q       <= dp_d;
        seg_ctrl_q <= seg_ctrl_d;
      end
    end
  end

  assign controls = controls_q;
  assign dp       = dp_q;
  assign seg_ctrl = seg_ctrl_q;
endmodule

// File: tb/tb_seg7_multi_driver.sv
// tb/tb_seg7_multi_driver.sv - directed self-checking bench for seg7_multi_driver
module tb_seg7_multi_driver;
  localparam int ND  = 4;
  localparam int BW  = 14;
  localparam int DIV = 4;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000, S4 = 7'b0011001, S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000, SA = 7'b0001000, SF = 7'b0001110;
  localparam logic [6:0] SD = 7'b0111111, SB = 7'b1111111;

  logic          clock_100 = 1'b0;
  logic          reset     = 1'b0;
  logic          blank_lz  = 1'b0;
  logic [ND-1:0] dp_mask   = '0;
  logic [6:0]    controls;
  logic          dp;
  logic [ND-1:0] seg_ctrl;
  logic          busy;
  logic          overflow;

  int tests = 0;
  int fails = 0;

  seg7_multi_driver_if #(.BIN_W(BW)) bus ();

  seg7_multi_driver #(
    .NUM_DIGITS (ND),
    .BIN_W      (BW),
    .DIV_COUNT  (DIV)
  ) dut (
    .clock_100 (clock_100),
    .reset     (reset),
    .bus       (bus),
    .blank_lz  (blank_lz),
    .dp_mask   (dp_mask),
    .controls  (controls),
    .dp        (dp),
    .seg_ctrl  (seg_ctrl),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clock_100 = ~clock_100;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock_100);
  endtask

  task automatic send(input logic [BW-1:0] v);
    int n;
    n = 0;
    while (bus.num_ready !== 1'b1 && n < 64) begin
      @(negedge clock_100);
      n++;
    end
    check("send_ready", 32'(n < 64), 32'd1);
    bus.num       = v;
    bus.num_valid = 1'b1;
    @(negedge clock_100);
    bus.num_valid = 1'b0;
    bus.num       = '0;
  endtask

  task automatic show(input string tag, input int d, input logic [6:0] exp_seg, input logic exp_dp);
    logic [ND-1:0] tgt;
    int n;
    tgt = ~(ND'(1) << d);
    n = 0;
    while (seg_ctrl !== tgt && n < 64) begin
      @(negedge clock_100);
      n++;
    end
    check({tag, "_found"}, 32'(n < 64), 32'd1);
    check(tag, 32'(controls), 32'(exp_seg));
    check({tag, "_dp"}, 32'(dp), 32'(exp_dp));
  endtask

  initial begin
    int n;
    int acc[$];
    bus.num       = '0;
    bus.num_valid = 1'b0;
`ifdef HEX_MODE_EN
    bus.hex_mode  = 1'b0;
`endif

    // reset state
    cyc(3);
    check("rst_controls", 32'(controls), 32'h7F);
    check("rst_dp", 32'(dp), 32'd1);
    check("rst_seg_ctrl", 32'(seg_ctrl), 32'hF);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b1;
    cyc(1);
    check("rdy_after_reset", 32'(bus.num_ready), 32'd1);

    // 1: 1234, ready low for BIN_W+1 cycles, scan order and slot timing
    send(14'd1234);
    check("t1_busy", 32'(busy), 32'd1);
    n = 0;
    while (bus.num_ready === 1'b0 && n < 64) begin
      n++;
      @(negedge clock_100);
    end
    check("t1_ready_low_cycles", 32'(n), 32'd15);
    cyc(DIV);
    n = 0;
    while (seg_ctrl !== 4'b0111 && n < 64) begin @(negedge clock_100); n++; end
    while (seg_ctrl !== 4'b1110 && n < 64) begin @(negedge clock_100); n++; end
    check("t1_slot_found", 32'(n < 64), 32'd1);
    check("t1_d0_ones", 32'(controls), 32'(S4));
    cyc(4);
    check("t1_seq_1101", 32'(seg_ctrl), 32'b1101);
    check("t1_d1", 32'(controls), 32'(S3));
    cyc(4);
    check("t1_seq_1011", 32'(seg_ctrl), 32'b1011);
    check("t1_d2", 32'(controls), 32'(S2));
    cyc(4);
    check("t1_seq_0111", 32'(seg_ctrl), 32'b0111);
    check("t1_d3", 32'(controls), 32'(S1));
    cyc(3);
    check("t1_slot_hold", 32'(seg_ctrl), 32'b0111);
    cyc(1);
    check("t1_seq_wrap", 32'(seg_ctrl), 32'b1110);

    // 2: leading-zero blanking, DP still shown on a blanked digit
    blank_lz = 1'b1;
    dp_mask  = 4'b0100;
    send(14'd7);
    cyc(BW + 1 + DIV);
    show("t2_d3_blank", 3, SB, 1'b1);
    show("t2_d2_blank", 2, SB, 1'b0);
    show("t2_d1_blank", 1, SB, 1'b1);
    show("t2_d0", 0, S7, 1'b1);
    blank_lz = 1'b0;
    dp_mask  = 4'b0000;
    cyc(DIV);
    show("t2_d3_zero", 3, S0, 1'b1);
    show("t2_d1_zero", 1, S0, 1'b1);

    // 3: overflow commit timing and dashes, then recovery
    send(14'd12000);
    cyc(14);
    check("t3_ovf_before", 32'(overflow), 32'd0);
    check("t3_rdy_before", 32'(bus.num_ready), 32'd0);
    cyc(1);
    check("t3_ovf_commit", 32'(overflow), 32'd1);
    check("t3_rdy_commit", 32'(bus.num_ready), 32'd1);
    blank_lz = 1'b1;
    cyc(DIV);
    show("t3_d3_dash", 3, SD, 1'b1);
    show("t3_d0_dash", 0, SD, 1'b1);
    send(14'd42);
    cyc(BW + 1 + DIV);
    check("t3_ovf_clear", 32'(overflow), 32'd0);
    show("t3_42_d3", 3, SB, 1'b1);
    show("t3_42_d2", 2, SB, 1'b1);
    show("t3_42_d1", 1, S4, 1'b1);
    show("t3_42_d0", 0, S2, 1'b1);
    blank_lz = 1'b0;
    cyc(DIV);
    show("t3_0042_d3", 3, S0, 1'b1);
    show("t3_0042_d2", 2, S0, 1'b1);
    send(14'd9999);
    cyc(BW + 1 + DIV);
    check("t3_9999_ovf", 32'(overflow), 32'd0);
    show("t3_9999_d3", 3, S9, 1'b1);

    // 4: valid held high with alternating values
    for (int k = 0; k < 48; k++) begin
      bus.num       = (k % 2 == 0) ? 14'd1111 : 14'd2222;
      bus.num_valid = 1'b1;
      if (bus.num_ready === 1'b1) acc.push_back(k);
      @(negedge clock_100);
    end
    bus.num_valid = 1'b0;
    check("t4_accepts", 32'(acc.size()), 32'd3);
    if (acc.size() >= 3) begin
      check("t4_gap1", 32'(acc[1] - acc[0]), 32'd16);
      check("t4_gap2", 32'(acc[2] - acc[1]), 32'd16);
    end
    cyc(DIV + 1);
    show("t4_d3", 3, S1, 1'b1);
    show("t4_d0", 0, S1, 1'b1);

    // 5: reset asserted in the middle of a conversion
    send(14'd12000);
    cyc(BW + 1 + DIV);
    check("t5_ovf_set", 32'(overflow), 32'd1);
    send(14'd5678);
    cyc(5);
    check("t5_busy_mid", 32'(busy), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("t5_async_seg_ctrl", 32'(seg_ctrl), 32'hF);
    check("t5_async_controls", 32'(controls), 32'h7F);
    check("t5_async_dp", 32'(dp), 32'd1);
    check("t5_async_ovf", 32'(overflow), 32'd0);
    check("t5_async_busy", 32'(busy), 32'd0);
    @(negedge clock_100);
    reset = 1'b1;
    @(negedge clock_100);
    check("t5_rdy", 32'(bus.num_ready), 32'd1);
    cyc(BW + 1 + DIV);
    check("t5_ovf_after", 32'(overflow), 32'd0);
    show("t5_d3", 3, S0, 1'b1);
    show("t5_d0", 0, S0, 1'b1);

`ifdef HEX_MODE_EN
    // 6: raw hex nibbles, single-cycle commit
    bus.hex_mode = 1'b1;
    send(14'h3AF0);
    bus.hex_mode = 1'b0;
    check("t6_rdy_low", 32'(bus.num_ready), 32'd0);
    cyc(1);
    check("t6_rdy_back", 32'(bus.num_ready), 32'd1);
    check("t6_ovf", 32'(overflow), 32'd0);
    cyc(DIV);
    show("t6_d3", 3, S3, 1'b1);
    show("t6_d2", 2, SA, 1'b1);
    show("t6_d1", 1, SF, 1'b1);
    show("t6_d0", 0, S0, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
